// File: rtl/alu_seq_if.sv
// Purpose : request/response bundle between register-read and the sequential ALU.
// Latency : n/a (wires only); the master issues operations and the slave returns results.
// Backpr. : valid/ready on both sides: in_valid/in_ready for requests, out_valid/out_ready for results.
// Ports   : request (in_valid, op, a, b, imm, imm_en, set_flags), in_ready,
//           response (out_valid, result, flags), out_ready, busy status.
interface alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IMM_W-1:0] imm;
    logic             imm_en;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, op, a, b, imm, imm_en, set_flags, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );

    modport slave (
        input  in_valid, op, a, b, imm, imm_en, set_flags, out_ready,
        output in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Purpose : registered ALU with persistent NZCV flags and a shift-add multiplier.
// Latency : 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL (handshake to out_valid).
// Backpr. : result/flags held while out_ready=0; in_ready follows out_ready when a result is pending.
// Ports   : clk, rst_n (async active-low), bus (alu_seq_if slave: request, response, busy).
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 8,
    parameter int MUL_EN = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             out_valid_q;
    logic             busy_q;

    // multiplier datapath
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             mul_sf;
    logic [WIDTH-1:0] acc_next;

    // single-cycle datapath
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             arith;
    logic             ovf;
    logic [WIDTH-1:0] alu_res;
    logic             upd;
    logic             is_mul;
    logic             hs;

    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.busy      = busy_q;

    assign hs     = bus.in_valid && bus.in_ready;
    assign is_mul = (bus.op == 4'd14) && (MUL_EN != 0);
    assign b_eff  = bus.imm_en ? WIDTH'(bus.imm) : bus.b;

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Subtraction is done as x + ~y + 1 so the adder carry is directly "not borrow",
    // and one overflow rule covers both add- and sub-type ops.
    always_comb begin
        x       = bus.a;
        y       = b_eff;
        cin     = 1'b0;
        arith   = 1'b0;
        alu_res = '0;
        case (bus.op)
            4'd0, 4'd11: arith = 1'b1;
            4'd1: begin
                arith = 1'b1;
                cin   = flags_q[1];
            end
            4'd2, 4'd10: begin
                arith = 1'b1;
                y     = ~b_eff;
                cin   = 1'b1;
            end
            4'd3: begin
                arith = 1'b1;
                x     = b_eff;
                y     = ~bus.a;
                cin   = 1'b1;
            end
            default: ;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        case (bus.op)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd10, 4'd11: alu_res = sum[WIDTH-1:0];
            4'd4, 4'd12:  alu_res = bus.a & b_eff;
            4'd5:         alu_res = bus.a | b_eff;
            4'd6, 4'd13:  alu_res = bus.a ^ b_eff;
            4'd7:         alu_res = bus.a & ~b_eff;
            4'd8:         alu_res = b_eff;
            4'd9:         alu_res = ~b_eff;
            default:      alu_res = '0;
        endcase
        // reserved (and MUL when not built) never touch the flags
        upd = (bus.op != 4'd15) && !(bus.op == 4'd14 && MUL_EN == 0) &&
              (bus.set_flags || (bus.op >= 4'd10 && bus.op <= 4'd13));
    end

    function automatic logic [3:0] flag_update(
        input logic [3:0]       old,
        input logic [WIDTH-1:0] res,
        input logic             en,
        input logic             cv_en,
        input logic             c,
        input logic             v
    );
        logic [3:0] f;
        f = old;
        if (en) begin
            f[3] = res[WIDTH-1];
            f[2] = (res == '0);
            if (cv_en) begin
                f[1] = c;
                f[0] = v;
            end
        end
        return f;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            result_q    <= '0;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            mul_sf      <= 1'b0;
        end else if (state == EXEC) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
                result_q    <= acc_next;
                flags_q     <= flag_update(flags_q, acc_next, mul_sf, 1'b0, 1'b0, 1'b0);
                out_valid_q <= 1'b1;
                busy_q      <= 1'b0;
                state       <= DONE;
            end
        end else begin
            if (state == DONE && bus.out_ready) begin
                out_valid_q <= 1'b0;
                state       <= IDLE;
            end
            // A handshake in DONE overrides the drain above: back-to-back issue.
            if (hs) begin
                if (is_mul) begin
                    mcand       <= bus.a;
                    mplier      <= b_eff;
                    acc         <= '0;
                    cnt         <= '0;
                    mul_sf      <= bus.set_flags;
                    busy_q      <= 1'b1;
                    out_valid_q <= 1'b0;
                    state       <= EXEC;
                end else begin
                    result_q    <= alu_res;
                    flags_q     <= flag_update(flags_q, alu_res, upd, arith, sum[WIDTH], ovf);
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W  = 32;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W), .IMM_W(IW)) bus();
    alu_seq #(.WIDTH(W), .IMM_W(IW), .MUL_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    int busy_cycles;
    int ready_viol;
    logic [3:0] model_flags;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  imm;
        logic        imm_en;
        logic        sf;
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: arithmetic done in 64-bit integers, C from unsigned compare/carry,
    // V from whether the true signed result fits in 32 bits.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] bv,
                                  input logic sf, input logic [3:0] fin,
                                  output logic [31:0] r, output logic [3:0] fo);
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(bv);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(bv));
        longint unsigned u  = 0;
        longint          s  = 0;
        logic c = 1'b0;
        logic arith = 1'b0;
        logic upd;
        r = '0;
        case (op)
            4'd0, 4'd11, 4'd1: begin
                u = ua + ub + ((op == 4'd1) ? longint'(fin[1]) : 0);
                s = sa + sb + ((op == 4'd1) ? longint'(fin[1]) : 0);
                r = u[31:0]; c = u[32]; arith = 1'b1;
            end
            4'd2, 4'd10: begin r = a - bv; c = (a >= bv); s = sa - sb; arith = 1'b1; end
            4'd3:        begin r = bv - a; c = (bv >= a); s = sb - sa; arith = 1'b1; end
            4'd4, 4'd12: r = a & bv;
            4'd5:        r = a | bv;
            4'd6, 4'd13: r = a ^ bv;
            4'd7:        r = a & ~bv;
            4'd8:        r = bv;
            4'd9:        r = ~bv;
            4'd14:       begin u = ua * ub; r = u[31:0]; end
            default:     r = '0;
        endcase
        upd = (op != 4'd15) && (sf || (op >= 4'd10 && op <= 4'd13));
        fo = fin;
        if (upd) begin
            fo[3] = r[31];
            fo[2] = (r == 32'd0);
            if (arith) begin
                fo[1] = c;
                fo[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
        end
    endfunction

    // Issue one op, wait for its result (out_ready held high), return result/flags/latency.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] imm, input logic ie, input logic sf,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        int n;
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.imm = imm; bus.imm_en = ie; bus.set_flags = sf;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("in_ready timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.imm = 8'($urandom); bus.op = 4'($urandom);
        lat = 0; busy_cycles = 0; ready_viol = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cycles++;
            if (bus.busy && bus.in_ready) ready_viol++;
        end while (!bus.out_valid && lat < 100);
        if (!bus.out_valid) check("out_valid timeout", 0, 1);
        r = bus.result;
        f = bus.flags;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, er, bv;
        logic [3:0]  f, ef;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [7:0]  imm;
        logic        ie, sf;
        int          lat;

        tbl[0]  = '{4'd0,  32'h7FFFFFFF, 32'h1,        8'h0,  1'b0, 1'b1, 32'h80000000, 4'b1001};
        tbl[1]  = '{4'd2,  32'd5,        32'd5,        8'h0,  1'b0, 1'b1, 32'h0,        4'b0110};
        tbl[2]  = '{4'd10, 32'd3,        32'd5,        8'h0,  1'b0, 1'b0, 32'hFFFFFFFE, 4'b1000};
        tbl[3]  = '{4'd5,  32'h100,      32'h12345678, 8'hFF, 1'b1, 1'b0, 32'h1FF,      4'b1000};
        tbl[4]  = '{4'd0,  32'hFFFFFFFF, 32'h1,        8'h0,  1'b0, 1'b1, 32'h0,        4'b0110};
        tbl[5]  = '{4'd1,  32'd1,        32'd1,        8'h0,  1'b0, 1'b1, 32'd3,        4'b0000};
        tbl[6]  = '{4'd3,  32'd3,        32'd10,       8'h0,  1'b0, 1'b1, 32'd7,        4'b0010};
        tbl[7]  = '{4'd4,  32'hF0F0,     32'hFF00,     8'h0,  1'b0, 1'b1, 32'hF000,     4'b0010};
        tbl[8]  = '{4'd6,  32'hFFFFFFFF, 32'h0,        8'h0,  1'b0, 1'b1, 32'hFFFFFFFF, 4'b1010};
        tbl[9]  = '{4'd7,  32'hFF,       32'h0F,       8'h0,  1'b0, 1'b0, 32'hF0,       4'b1010};
        tbl[10] = '{4'd9,  32'h0,        32'h0,        8'h0,  1'b0, 1'b1, 32'hFFFFFFFF, 4'b1010};
        tbl[11] = '{4'd8,  32'h5,        32'h0,        8'h0,  1'b0, 1'b1, 32'h0,        4'b0110};
        tbl[12] = '{4'd12, 32'hF0,       32'h0F,       8'h0,  1'b0, 1'b0, 32'h0,        4'b0110};
        tbl[13] = '{4'd13, 32'h80000000, 32'h0,        8'h0,  1'b0, 1'b0, 32'h80000000, 4'b1010};
        tbl[14] = '{4'd11, 32'h80000000, 32'h80000000, 8'h0,  1'b0, 1'b0, 32'h0,        4'b0111};
        tbl[15] = '{4'd2,  32'h80000000, 32'h1,        8'h0,  1'b0, 1'b1, 32'h7FFFFFFF, 4'b0011};
        tbl[16] = '{4'd15, 32'd5,        32'd5,        8'h0,  1'b0, 1'b1, 32'h0,        4'b0011};
        tbl[17] = '{4'd14, 32'd1234,     32'd5678,     8'h0,  1'b0, 1'b0, 32'd7006652,  4'b0011};
        tbl[18] = '{4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h0,  1'b0, 1'b1, 32'h1,        4'b0011};
        tbl[19] = '{4'd1,  32'hFFFFFFFF, 32'h0,        8'h0,  1'b0, 1'b1, 32'h0,        4'b0110};

        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.imm = '0; bus.imm_en = 1'b0; bus.set_flags = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", bus.out_valid, 0);
        check("reset busy", bus.busy, 0);
        check("reset result", bus.result, 0);
        check("reset flags", bus.flags, 0);
        check("reset in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].imm_en, tbl[i].sf, r, f, lat);
            check($sformatf("tbl%0d result", i), r, tbl[i].exp_r);
            check($sformatf("tbl%0d flags", i), f, tbl[i].exp_f);
            check($sformatf("tbl%0d latency", i), lat, (tbl[i].op == 4'd14) ? 33 : 1);
            check($sformatf("tbl%0d busy cycles", i), busy_cycles, (tbl[i].op == 4'd14) ? 32 : 0);
            check($sformatf("tbl%0d in_ready while busy", i), ready_viol, 0);
        end
        model_flags = 4'b0110;

        // Backpressure: hold result for three cycles, then accept with a back-to-back ADD.
        @(negedge clk);
        bus.op = 4'd0; bus.a = 32'd10; bus.b = 32'd20; bus.imm_en = 1'b0; bus.set_flags = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.a = $urandom;
        model(4'd0, 32'd10, 32'd20, 1'b1, model_flags, er, ef);
        model_flags = ef;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d out_valid", i), bus.out_valid, 1);
            check($sformatf("stall%0d result", i), bus.result, er);
            check($sformatf("stall%0d flags", i), bus.flags, ef);
            check($sformatf("stall%0d in_ready", i), bus.in_ready, 0);
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.op = 4'd0; bus.a = 32'd1; bus.b = 32'd2; bus.set_flags = 1'b1;
        #1;
        check("b2b in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        model(4'd0, 32'd1, 32'd2, 1'b1, model_flags, er, ef);
        model_flags = ef;
        @(negedge clk);
        check("b2b out_valid", bus.out_valid, 1);
        check("b2b result", bus.result, er);
        check("b2b flags", bus.flags, ef);
        @(negedge clk);
        check("b2b drained", bus.out_valid, 0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.op = 4'd14; bus.a = 32'd1234; bus.b = 32'd5678; bus.set_flags = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("midmul busy", bus.busy, 1);
        check("midmul in_ready", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", bus.out_valid, 0);
        check("abort busy", bus.busy, 0);
        check("abort flags", bus.flags, 0);
        check("abort result", bus.result, 0);
        check("abort in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_flags = 4'b0000;
        run_op(4'd2, 32'd2, 32'd3, 8'h0, 1'b0, 1'b1, r, f, lat);
        model(4'd2, 32'd2, 32'd3, 1'b1, model_flags, er, ef);
        model_flags = ef;
        check("post-reset result", r, er);
        check("post-reset flags", f, ef);
        check("post-reset latency", lat, 1);

        // Randomised ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = 8'($urandom);
            ie  = 1'($urandom_range(0, 1));
            sf  = 1'($urandom_range(0, 1));
            bv  = ie ? {24'd0, imm} : b;
            model(op, a, bv, sf, model_flags, er, ef);
            run_op(op, a, b, imm, ie, sf, r, f, lat);
            check($sformatf("rand%0d op%0d result", i, op), r, er);
            check($sformatf("rand%0d op%0d flags", i, op), f, ef);
            check($sformatf("rand%0d op%0d latency", i, op), lat, (op == 4'd14) ? 33 : 1);
            model_flags = ef;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
